sha256_nonce_sched: RTL and testbench

- Sequences a pool of simplified SHA-256 workers to hash one Bitcoin header tail across NUM_NONCES nonces.
- Per nonce, the block runs phase 2 on the captured midstate, then phase 3 on the worker's own phase-2 digest, and writes word 0 of the final digest to memory.
- Sits between the top-level bitcoin_hash control and the worker instances; the workers are instantiated at top level, not inside this block.

---
 rtl/bitcoin_pkg.sv | 23 ++
 rtl/nonce_result_writer.sv | 43 ++++
 rtl/sha256_nonce_sched.sv | 194 +++++++++++++++++++
 tb/tb_sha256_nonce_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce scheduler and its result writer.
package bitcoin_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [7:0] digest_t;

  // Element 0 is H0 (0x6a09e667).
  localparam digest_t H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P2_GO   = 3'd1,
    P2_WAIT = 3'd2,
    P3_GO   = 3'd3,
    P3_WAIT = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } sched_state_e;

endpackage

// File: rtl/nonce_result_writer.sv
// Serialises one batch of final H0 words to memory, one word per cycle while go is high.
module nonce_result_writer
  import bitcoin_pkg::*;
#(
  parameter int NUM_WORKERS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [15:0]             base,
  input  word_t [NUM_WORKERS-1:0] h0,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output word_t                   mem_wdata,
  output logic                    wr_done
);

  localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORKERS - 1);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (go) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Address and data are forced to zero outside a write so idle outputs stay quiet.
  always_comb begin
    mem_we    = go;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_done   = go && (idx == LAST_IDX);
    if (go) begin
      mem_addr  = base + 16'(idx);
      mem_wdata = h0[idx];
    end
  end

endmodule

// File: rtl/sha256_nonce_sched.sv
// Drives a pool of SHA-256 workers through phase 2 and phase 3 for every nonce of a job
// and writes word 0 of each final digest to memory.
module sha256_nonce_sched
  import bitcoin_pkg::*;
#(
  parameter int NUM_WORKERS    = 4,
  parameter int NUM_NONCES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  digest_t                           midstate,
  input  word_t [2:0]                       msg_tail,
  input  logic [15:0]                       out_base,
  output logic                              done,
  output logic                              error,
  output logic [NUM_WORKERS-1:0]            w_start,
  output logic                              w_phase_sel,
  output logic [NUM_WORKERS-1:0][3:0]       w_nonce,
  output digest_t [NUM_WORKERS-1:0]         w_hi,
  output word_t [2:0]                       w_msg_tail,
  input  digest_t [NUM_WORKERS-1:0]         w_ho,
  input  logic [NUM_WORKERS-1:0]            w_finish,
  output logic                              mem_we,
  output logic [15:0]                       mem_addr,
  output word_t                             mem_wdata,
  output sched_state_e                      dbg_state
);

  localparam int NUM_BATCHES = NUM_NONCES / NUM_WORKERS;
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      LAST_BATCH = 4'(NUM_BATCHES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  // Handshake: w_start is a one-cycle pulse per run; w_finish is a level that the worker
  // drops on the edge sampling w_start, so it is only trusted in the WAIT states.

  sched_state_e state, next_state;

  logic [3:0]                        batch;
  logic [TO_W-1:0]                   tcnt;
  digest_t                           mid_q;
  word_t [2:0]                       tail_q;
  logic [15:0]                       base_q;
  digest_t [NUM_WORKERS-1:0]         p2_q;
  word_t [NUM_WORKERS-1:0]           h0_q;
  logic [NUM_WORKERS-1:0][3:0]       nonce_q;
  logic                              phase_q;
  logic                              error_q;

  logic capture, p2_latch, p3_latch, tmo, batch_adv, wr_go, wr_done;
  logic all_fin, tmo_hit;

  function automatic logic [NUM_WORKERS-1:0][3:0] nonce_vec(input logic [3:0] b);
    logic [NUM_WORKERS-1:0][3:0] v;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      v[i] = 4'(int'(b) * NUM_WORKERS + i);
    end
    return v;
  endfunction

  assign all_fin = &w_finish;
  assign tmo_hit = (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      batch   <= '0;
      tcnt    <= '0;
      mid_q   <= '0;
      tail_q  <= '0;
      base_q  <= '0;
      p2_q    <= '0;
      h0_q    <= '0;
      nonce_q <= '0;
      phase_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        mid_q   <= midstate;
        tail_q  <= msg_tail;
        base_q  <= out_base;
        error_q <= 1'b0;
        batch   <= '0;
        nonce_q <= nonce_vec(4'd0);
      end
      if (batch_adv) begin
        batch   <= batch + 4'd1;
        nonce_q <= nonce_vec(batch + 4'd1);
      end
      if (state == P2_GO) phase_q <= 1'b0;
      if (state == P3_GO) phase_q <= 1'b1;
      if (state == P2_WAIT || state == P3_WAIT) tcnt <= tcnt + 1'b1;
      else                                      tcnt <= '0;
      if (p2_latch) p2_q <= w_ho;
      if (p3_latch) begin
        for (int i = 0; i < NUM_WORKERS; i++) h0_q[i] <= w_ho[i][0];
      end
      if (tmo) error_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    w_start    = '0;
    wr_go      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    p2_latch   = 1'b0;
    p3_latch   = 1'b0;
    tmo        = 1'b0;
    batch_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          next_state = P2_GO;
        end
      end
      P2_GO: begin
        w_start    = '1;
        next_state = P2_WAIT;
      end
      P2_WAIT: begin
        if (all_fin) begin
          p2_latch   = 1'b1;
          next_state = P3_GO;
        end else if (tmo_hit) begin
          tmo        = 1'b1;
          next_state = IDLE;
        end
      end
      P3_GO: begin
        w_start    = '1;
        next_state = P3_WAIT;
      end
      P3_WAIT: begin
        if (all_fin) begin
          p3_latch   = 1'b1;
          next_state = WRITE;
        end else if (tmo_hit) begin
          tmo        = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        wr_go = 1'b1;
        if (wr_done) begin
          if (batch == LAST_BATCH) begin
            next_state = DONE;
          end else begin
            batch_adv  = 1'b1;
            next_state = P2_GO;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Phase select is driven directly in the GO cycles and otherwise holds its last value.
  always_comb begin
    w_phase_sel = (state == P3_GO) || ((state != P2_GO) && phase_q);
    for (int i = 0; i < NUM_WORKERS; i++) begin
      w_hi[i] = w_phase_sel ? p2_q[i] : mid_q;
    end
  end

  assign w_nonce    = nonce_q;
  assign w_msg_tail = tail_q;
  assign error      = error_q;
  assign dbg_state  = state;

  nonce_result_writer #(
    .NUM_WORKERS(NUM_WORKERS)
  ) u_writer (
    .clk      (clk),
    .reset    (reset),
    .go       (wr_go),
    .base     (base_q + {12'h000, nonce_q[0]}),
    .h0       (h0_q),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .wr_done  (wr_done)
  );

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed bench for sha256_nonce_sched using behavioural stub workers with adjustable latency.
module tb_sha256_nonce_sched;
  import bitcoin_pkg::*;

  localparam int NW = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  digest_t                midstate;
  word_t [2:0]            msg_tail;
  logic [15:0]            out_base;
  logic                   done;
  logic                   error;
  logic [NW-1:0]          w_start;
  logic                   w_phase_sel;
  logic [NW-1:0][3:0]     w_nonce;
  digest_t [NW-1:0]       w_hi;
  word_t [2:0]            w_msg_tail;
  digest_t [NW-1:0]       w_ho;
  logic [NW-1:0]          w_finish;
  logic                   mem_we;
  logic [15:0]            mem_addr;
  word_t                  mem_wdata;
  sched_state_e           dbg_state;

  // Stub worker controls
  logic stub_rst;
  int   lat [NW];
  logic hang [NW];
  int   cnt [NW];
  digest_t    cap_hi [NW];
  logic       cap_ph [NW];
  logic [3:0] cap_n  [NW];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [15:0] got_addr [$];
  word_t       got_data [$];
  logic [15:0] exp_addr_q [$];
  word_t       exp_q [$];
  digest_t     mid_exp;

  sha256_nonce_sched dut (
    .clk(clk), .reset(reset), .start(start), .midstate(midstate), .msg_tail(msg_tail),
    .out_base(out_base), .done(done), .error(error), .w_start(w_start),
    .w_phase_sel(w_phase_sel), .w_nonce(w_nonce), .w_hi(w_hi), .w_msg_tail(w_msg_tail),
    .w_ho(w_ho), .w_finish(w_finish), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic digest_t stub_digest(input digest_t hi, input logic ph, input logic [3:0] n);
    digest_t d;
    for (int k = 0; k < 8; k++) begin
      d[k] = (hi[k] ^ 32'h5a5a0000) + (ph ? 32'h100 : 32'h0) + {16'h0, n, 12'h000} + 32'(k);
    end
    return d;
  endfunction

  // Stub worker: finish drops on the start edge and rises lat edges later with the digest.
  always @(posedge clk) begin
    if (stub_rst) begin
      w_finish <= '0;
      w_ho     <= '0;
      for (int i = 0; i < NW; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (w_start[i]) begin
          w_finish[i] <= 1'b0;
          cnt[i]      <= lat[i];
          cap_hi[i]   <= w_hi[i];
          cap_ph[i]   <= w_phase_sel;
          cap_n[i]    <= w_nonce[i];
        end else if (cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1 && !hang[i]) begin
            w_finish[i] <= 1'b1;
            w_ho[i]     <= stub_digest(cap_hi[i], cap_ph[i], cap_n[i]);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples #1 after the edge and records writes/done pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  endtask

  task automatic begin_job(input digest_t mid, input word_t [2:0] tail, input logic [15:0] base);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    mid_exp  = mid;
    midstate = mid;
    msg_tail = tail;
    out_base = base;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_job(input digest_t mid, input word_t [2:0] tail, input logic [15:0] base,
                         input int exp_cycles, input bit stale, input bit pulse);
    int  n;
    bit  pulsed;
    digest_t p2;
    begin_job(mid, tail, base);
    n = 1;
    pulsed = 1'b0;
    check("go_state", dbg_state, P2_GO);
    check("go_wstart", w_start, 4'hf);
    check("go_phase", w_phase_sel, 1'b0);
    check("go_nonce", w_nonce, 16'h3210);
    check("go_hi_mid", w_hi[3], mid);
    check("go_tail", w_msg_tail, tail);
    check("go_err_clr", error, 1'b0);
    while (!done && n < 2000) begin
      tick();
      n++;
      start = 1'b0;
      if (n == 2) begin
        check("wait_state", dbg_state, P2_WAIT);
        check("wait_wstart", w_start, 4'h0);
        if (stale) check("stale_fin_low", w_finish, 4'h0);
      end
      if (n == 3 && stale) check("stale_no_adv", dbg_state, P2_WAIT);
      if (w_start != 0 && w_phase_sel) begin
        check("p3go_all_fin", w_finish, 4'hf);
        check("p3go_nonce2_lsb", w_nonce[2][1:0], 2'd2);
        check("p3go_hi2", w_hi[2], stub_digest(mid, 1'b0, w_nonce[2]));
      end
      if (pulse && mem_we && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    check("job_cycles", n, exp_cycles);
    tick();
    check("job_done_cnt", done_cnt, 1);
    check("job_idle", dbg_state, IDLE);
    check("job_err", error, 1'b0);
    // Scoreboard: nonces are written in order at base+n.
    exp_addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      p2 = stub_digest(mid, 1'b0, 4'(k));
      exp_addr_q.push_back(base + 16'(k));
      exp_q.push_back(stub_digest(p2, 1'b1, 4'(k))[0]);
    end
    check("wr_count", got_addr.size(), 16);
    while (exp_q.size() > 0 && got_addr.size() > 0) begin
      check("wr_addr", got_addr.pop_front(), exp_addr_q.pop_front());
      check("wr_data", got_data.pop_front(), exp_q.pop_front());
    end
  endtask

  digest_t mid2;
  word_t [2:0] tail0;
  word_t [2:0] tail1;
  int n;

  initial begin
    reset    = 1'b1;
    stub_rst = 1'b1;
    start    = 1'b0;
    midstate = '0;
    msg_tail = '0;
    out_base = '0;
    for (int i = 0; i < NW; i++) begin
      lat[i]  = 65;
      hang[i] = 1'b0;
    end
    tail0 = '0;
    tail1 = {32'h00000280, 32'h80000000, 32'h1234abcd};
    mid2  = H_INIT;
    mid2[0] = 32'hdeadbeef;
    mid2[2] = 32'h01020304;
    repeat (3) tick();
    reset    = 1'b0;
    stub_rst = 1'b0;

    check("rst_state", dbg_state, IDLE);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_wstart", w_start, 4'h0);
    check("rst_nonce", w_nonce, 16'h0);
    check("rst_hi_zero", (w_hi === '0), 1'b1);
    check("rst_memwe", mem_we, 1'b0);

    // Reference timing job.
    run_job(H_INIT, tail0, 16'h0100, 553, 1'b0, 1'b0);

    // Worker 2 finishes 10 cycles late in both phases; finish flags are stale from the last job.
    lat[2] = 75;
    run_job(mid2, tail1, 16'h0200, 633, 1'b1, 1'b0);
    lat[2] = 65;

    // Wrapping base address and a start pulse during WRITE that must be ignored.
    run_job(H_INIT, tail1, 16'hfff8, 553, 1'b1, 1'b1);

    // Timeout: worker 1 never finishes.
    hang[1] = 1'b1;
    begin_job(H_INIT, tail0, 16'h0300);
    n = 1;
    while (!error && n < 600) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 257);
    check("tmo_state", dbg_state, IDLE);
    repeat (20) tick();
    check("tmo_no_writes", got_addr.size(), 0);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_sticky", error, 1'b1);
    hang[1] = 1'b0;

    // Fresh start clears the error; then reset mid-job at cycle 200.
    begin_job(H_INIT, tail0, 16'h0400);
    check("restart_err_clr", error, 1'b0);
    n = 1;
    while (n < 200) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_state", dbg_state, IDLE);
    check("rstmid_wstart", w_start, 4'h0);
    check("rstmid_phase", w_phase_sel, 1'b0);
    check("rstmid_nonce", w_nonce, 16'h0);
    check("rstmid_hi_zero", (w_hi === '0), 1'b1);
    check("rstmid_tail", w_msg_tail, 96'h0);
    check("rstmid_memwe", mem_we, 1'b0);
    check("rstmid_addr", mem_addr, 16'h0);
    check("rstmid_err", error, 1'b0);
    got_addr.delete();
    got_data.delete();
    repeat (30) tick();
    check("rstmid_late_fin_ignored", dbg_state, IDLE);
    check("rstmid_no_writes", got_addr.size(), 0);

    run_job(mid2, tail0, 16'h0500, 553, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
